// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode and mux encodings for the multicycle MIPS controller.
// MC_ILLEGAL_HALT_EN selects halting on unsupported opcodes instead of treating them as NOPs.
package mips_ctrl_pkg;
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEM_ADR = 4'd3,
        MEM_RD  = 4'd4,
        MEM_WB  = 4'd5,
        MEM_WR  = 4'd6,
        EXEC    = 4'd7,
        ALU_WB  = 4'd8,
        BRANCH  = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11,
        JUMP    = 4'd12,
        HALT    = 4'd13
    } state_t;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
`ifdef MC_ILLEGAL_HALT_EN
    localparam bit ILLEGAL_HALT = 1'b1;
`else
    localparam bit ILLEGAL_HALT = 1'b0;
`endif
    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction
endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: state (plus Mem_Ready and opcode) to datapath control word.
// Only FETCH/MEM_WR strobes and the DECODE NOP completion depend on inputs.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic        mem_ready,
    input  logic [5:0]  op,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        instr_done
);
    always_comb begin
        pc_write = 1'b0;
        pc_write_cond = 1'b0;
        iord = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        ir_write = 1'b0;
        reg_dst = 1'b0;
        mem_to_reg = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_REG;
        alu_op = ALUOP_ADD;
        pc_source = PCS_ALU;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                mem_read = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                instr_done = !ILLEGAL_HALT && !op_legal(op);
            end
            MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                iord = 1'b1;
                mem_read = 1'b1;
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                iord = 1'b1;
                mem_write = 1'b1;
                instr_done = mem_ready;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op = ALUOP_FUNCT;
            end
            ALU_WB: begin
                reg_dst = 1'b1;
                reg_write = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source = PCS_ALUOUT;
                instr_done = 1'b1;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_source = PCS_JUMP;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: MIPS multicycle FSM with memory-stall watchdog and sticky fault flags.
// MC_ILLEGAL_HALT_EN: unsupported opcodes halt the core and set Illegal.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  OP,
    input  logic        Mem_Ready,
    output logic        PC_Write,
    output logic        PC_Write_Cond,
    output logic        IorD,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        IR_Write,
    output logic        Reg_Dst,
    output logic        Mem_to_Reg,
    output logic        Reg_Write,
    output logic        ALU_Src_A,
    output logic [1:0]  ALU_Src_B,
    output logic [1:0]  ALU_OP,
    output logic [1:0]  PC_Source,
    output logic        Instr_Done,
    output logic        Illegal,
    output logic        Mem_Err,
    output logic [3:0]  State
);
    state_t state;
    logic [7:0] cnt;
    logic mem_err;
    // cnt defaults to zero so any state change clears it; only a stall keeps counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            mem_err <= 1'b0;
        end else begin
            cnt <= '0;
            case (state)
                IDLE: state <= FETCH;
                FETCH, MEM_RD, MEM_WR: begin
                    if (Mem_Ready)
                        state <= (state == FETCH) ? DECODE : (state == MEM_RD) ? MEM_WB : FETCH;
                    else if (MEM_TIMEOUT != 0 && cnt == 8'(MEM_TIMEOUT - 1)) begin
                        state <= HALT;
                        mem_err <= 1'b1;
                    end else
                        cnt <= cnt + 8'd1;
                end
                DECODE: begin
                    case (OP)
                        OP_LW, OP_SW: state <= MEM_ADR;
                        OP_R:         state <= EXEC;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDI_EX;
                        OP_J:         state <= JUMP;
                        default:      state <= ILLEGAL_HALT ? HALT : FETCH;
                    endcase
                end
                MEM_ADR: state <= (OP == OP_LW) ? MEM_RD : MEM_WR;
                EXEC:    state <= ALU_WB;
                ADDI_EX: state <= ADDI_WB;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end
`ifdef MC_ILLEGAL_HALT_EN
    logic illegal;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal <= 1'b0;
        else if (state == DECODE && !op_legal(OP))
            illegal <= 1'b1;
    end
    assign Illegal = illegal;
`else
    assign Illegal = 1'b0;
`endif
    assign Mem_Err = mem_err;
    assign State = state;
    mc_output_decode u_decode (
        .state(state),
        .mem_ready(Mem_Ready),
        .op(OP),
        .pc_write(PC_Write),
        .pc_write_cond(PC_Write_Cond),
        .iord(IorD),
        .mem_read(Mem_Read),
        .mem_write(Mem_Write),
        .ir_write(IR_Write),
        .reg_dst(Reg_Dst),
        .mem_to_reg(Mem_to_Reg),
        .reg_write(Reg_Write),
        .alu_src_a(ALU_Src_A),
        .alu_src_b(ALU_Src_B),
        .alu_op(ALU_OP),
        .pc_source(PC_Source),
        .instr_done(Instr_Done)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench; each planned cycle carries its stimulus and expected control word.
module tb_multicycle_controller;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
`ifdef MC_ILLEGAL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, Mem_Ready = 1'b0;
    logic [5:0] OP = 6'd0;
    logic PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg;
    logic Reg_Write, ALU_Src_A, Instr_Done, Illegal, Mem_Err;
    logic [1:0] ALU_Src_B, ALU_OP, PC_Source;
    logic [3:0] State;
    int compared = 0, mismatched = 0, dones = 0;
    typedef struct {
        logic [3:0]  st;
        logic        rdy;
        logic [5:0]  op;
        logic [20:0] exp;
    } step_t;
    step_t sb[$];
    always #5 clk = ~clk;
    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .OP(OP), .Mem_Ready(Mem_Ready),
        .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond), .IorD(IorD),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
        .Reg_Dst(Reg_Dst), .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write),
        .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALU_OP(ALU_OP),
        .PC_Source(PC_Source), .Instr_Done(Instr_Done), .Illegal(Illegal),
        .Mem_Err(Mem_Err), .State(State)
    );
    function automatic logic [20:0] dut_word();
        return {State, PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Dst,
                Mem_to_Reg, Reg_Write, ALU_Src_A, ALU_Src_B, ALU_OP, PC_Source, Instr_Done};
    endfunction
    // Expected control word straight from the state table of the controller description
    function automatic logic [20:0] model(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, rd = 0, mtr = 0, rw = 0, sa = 0, dn = 0;
        logic [1:0] sbs = 0, ao = 0, ps = 0;
        logic legal = op inside {R, LW, SW, BEQ, ADDI, J};
        case (st)
            4'd1: begin iord = 0; mr = 1; sbs = 2'b01; irw = rdy; pcw = rdy; end
            4'd2: begin sbs = 2'b11; dn = !legal && !HALT_EN; end
            4'd3: begin sa = 1; sbs = 2'b10; end
            4'd4: begin iord = 1; mr = 1; end
            4'd5: begin mtr = 1; rw = 1; dn = 1; end
            4'd6: begin iord = 1; mw = 1; dn = rdy; end
            4'd7: begin sa = 1; ao = 2'b10; end
            4'd8: begin rd = 1; rw = 1; dn = 1; end
            4'd9: begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; dn = 1; end
            4'd10: begin sa = 1; sbs = 2'b10; end
            4'd11: begin rw = 1; dn = 1; end
            4'd12: begin pcw = 1; ps = 2'b10; dn = 1; end
            default: ;
        endcase
        return {st, pcw, pcwc, iord, mr, mw, irw, rd, mtr, rw, sa, sbs, ao, ps, dn};
    endfunction
    task automatic plan(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        step_t s;
        s.st = st; s.rdy = rdy; s.op = op; s.exp = model(st, rdy, op);
        sb.push_back(s);
    endtask
    task automatic test_reset();
        step_t s;
        @(posedge clk); #1;
        compared++;
        if ({dut_word(), Illegal, Mem_Err} !== 23'd0) begin
            mismatched++; $display("FAIL reset: outputs got %h want 0", {dut_word(), Illegal, Mem_Err});
        end
        rst_n = 1'b1;
        plan(4'd0, 1'b0, R);
        while (sb.size() > 0) begin
            s = sb.pop_front(); Mem_Ready = s.rdy; OP = s.op;
            @(negedge clk);
            compared++;
            if (dut_word() !== s.exp) begin
                mismatched++; $display("FAIL reset_idle: word got %h want %h", dut_word(), s.exp);
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_rtype();
        step_t s;
        dones = 0;
        plan(4'd1, 1'b1, R); plan(4'd2, 1'b1, R); plan(4'd7, 1'b1, R); plan(4'd8, 1'b1, R);
        while (sb.size() > 0) begin
            s = sb.pop_front(); Mem_Ready = s.rdy; OP = s.op;
            @(negedge clk);
            compared++;
            if (dut_word() !== s.exp) begin
                mismatched++; $display("FAIL rtype st%0d: word got %h want %h", s.st, dut_word(), s.exp);
            end
            dones += int'(Instr_Done);
            @(posedge clk); #1;
        end
        compared++;
        if (dones !== 1) begin mismatched++; $display("FAIL rtype_done: count got %0d want 1", dones); end
    endtask
    task automatic test_mem();
        step_t s;
        dones = 0;
        plan(4'd1, 1'b1, LW); plan(4'd2, 1'b1, LW); plan(4'd3, 1'b1, LW);
        for (int i = 0; i < 3; i++) plan(4'd4, 1'b0, LW);
        plan(4'd4, 1'b1, LW); plan(4'd5, 1'b1, LW);
        plan(4'd1, 1'b1, SW); plan(4'd2, 1'b0, SW); plan(4'd3, 1'b0, SW); plan(4'd6, 1'b1, SW);
        while (sb.size() > 0) begin
            s = sb.pop_front(); Mem_Ready = s.rdy; OP = s.op;
            @(negedge clk);
            compared++;
            if (dut_word() !== s.exp) begin
                mismatched++; $display("FAIL mem st%0d: word got %h want %h", s.st, dut_word(), s.exp);
            end
            dones += int'(Instr_Done);
            @(posedge clk); #1;
        end
        compared++;
        if (dones !== 2) begin mismatched++; $display("FAIL mem_done: count got %0d want 2", dones); end
    endtask
    task automatic test_branch_jump();
        step_t s;
        dones = 0;
        plan(4'd1, 1'b1, BEQ); plan(4'd2, 1'b0, BEQ); plan(4'd9, 1'b1, BEQ);
        plan(4'd1, 1'b1, J); plan(4'd2, 1'b1, J); plan(4'd12, 1'b0, J);
        plan(4'd1, 1'b1, ADDI); plan(4'd2, 1'b1, ADDI); plan(4'd10, 1'b1, ADDI); plan(4'd11, 1'b1, ADDI);
        while (sb.size() > 0) begin
            s = sb.pop_front(); Mem_Ready = s.rdy; OP = s.op;
            @(negedge clk);
            compared++;
            if (dut_word() !== s.exp) begin
                mismatched++; $display("FAIL br_j_addi st%0d: word got %h want %h", s.st, dut_word(), s.exp);
            end
            dones += int'(Instr_Done);
            @(posedge clk); #1;
        end
        compared++;
        if (dones !== 3) begin mismatched++; $display("FAIL br_j_addi_done: count got %0d want 3", dones); end
    endtask
    task automatic test_watchdog_edges();
        step_t s;
        for (int i = 0; i < 3; i++) plan(4'd1, 1'b0, J);
        plan(4'd1, 1'b1, J); plan(4'd2, 1'b1, J); plan(4'd12, 1'b1, J);
        for (int i = 0; i < 3; i++) plan(4'd1, 1'b0, LW);
        plan(4'd1, 1'b1, LW); plan(4'd2, 1'b0, LW); plan(4'd3, 1'b0, LW);
        for (int i = 0; i < 3; i++) plan(4'd4, 1'b0, LW);
        plan(4'd4, 1'b1, LW); plan(4'd5, 1'b0, LW);
        while (sb.size() > 0) begin
            s = sb.pop_front(); Mem_Ready = s.rdy; OP = s.op;
            @(negedge clk);
            compared++;
            if ({dut_word(), Mem_Err} !== {s.exp, 1'b0}) begin
                mismatched++; $display("FAIL wdog_edge st%0d: word/err got %h want %h", s.st, {dut_word(), Mem_Err}, {s.exp, 1'b0});
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_unsupported();
        step_t s;
        dones = 0;
        plan(4'd1, 1'b1, BAD); plan(4'd2, 1'b0, BAD);
        if (HALT_EN) begin plan(4'd13, 1'b1, BAD); plan(4'd13, 1'b0, R); end
        else plan(4'd1, 1'b0, BAD);
        while (sb.size() > 0) begin
            s = sb.pop_front(); Mem_Ready = s.rdy; OP = s.op;
            @(negedge clk);
            compared++;
            if (dut_word() !== s.exp) begin
                mismatched++; $display("FAIL unsupported st%0d: word got %h want %h", s.st, dut_word(), s.exp);
            end
            dones += int'(Instr_Done);
            @(posedge clk); #1;
        end
        compared++;
        if ({Illegal, dones} !== {HALT_EN, (HALT_EN ? 32'd0 : 32'd1)}) begin
            mismatched++; $display("FAIL unsupported_flags: illegal/done got %0b/%0d want %0b/%0d", Illegal, dones, HALT_EN, !HALT_EN);
        end
    endtask
    task automatic test_async_reset();
        step_t s;
        rst_n = 1'b0; #1;
        compared++;
        if ({State, Illegal} !== 5'd0) begin
            mismatched++; $display("FAIL async_pre: state/illegal got %h want 0", {State, Illegal});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        plan(4'd0, 1'b0, SW); plan(4'd1, 1'b1, SW); plan(4'd2, 1'b0, SW); plan(4'd3, 1'b0, SW);
        plan(4'd6, 1'b0, SW); plan(4'd6, 1'b0, SW);
        while (sb.size() > 0) begin
            s = sb.pop_front(); Mem_Ready = s.rdy; OP = s.op;
            @(negedge clk);
            compared++;
            if (dut_word() !== s.exp) begin
                mismatched++; $display("FAIL async st%0d: word got %h want %h", s.st, dut_word(), s.exp);
            end
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0; #1;
        compared++;
        if (dut_word() !== 21'd0) begin
            mismatched++; $display("FAIL async_abort: word got %h want 0", dut_word());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        plan(4'd0, 1'b0, R);
        while (sb.size() > 0) begin
            s = sb.pop_front(); Mem_Ready = s.rdy; OP = s.op;
            @(negedge clk);
            compared++;
            if (dut_word() !== s.exp) begin
                mismatched++; $display("FAIL async_restart: word got %h want %h", dut_word(), s.exp);
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_timeout();
        step_t s;
        for (int i = 0; i < 4; i++) plan(4'd1, 1'b0, R);
        for (int i = 0; i < 3; i++) plan(4'd13, 1'b1, R);
        while (sb.size() > 0) begin
            s = sb.pop_front(); Mem_Ready = s.rdy; OP = s.op;
            @(negedge clk);
            compared++;
            if ({dut_word(), Mem_Err} !== {s.exp, s.st == 4'd13}) begin
                mismatched++; $display("FAIL timeout st%0d: word/err got %h want %h", s.st, {dut_word(), Mem_Err}, {s.exp, s.st == 4'd13});
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0; #1;
        compared++;
        if ({State, Mem_Err} !== 5'd0) begin
            mismatched++; $display("FAIL timeout_clear: state/err got %h want 0", {State, Mem_Err});
        end
    endtask
    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_branch_jump();
        test_watchdog_edges();
        test_unsupported();
        test_async_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
